mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_pkg.sv | 18 +
 rtl/boot_loader_seq.sv | 38 +++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the memory arbiter: FSM states, starvation limit, requester ids.
package cpu_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IF   = 2'd1,
    REQ_DM   = 2'd2
  } req_id_e;

  localparam int unsigned STARVE_LIM = 8;
  localparam int unsigned STARVE_W   = 4;

endpackage

// File: rtl/boot_loader_seq.sv
// Boot write sequencer: produces one memory write per BIOS word at increasing addresses
// and signals when boot must end (end marker or BOOT_MAX words written).
module boot_loader_seq #(
  parameter int unsigned BOOT_MAX = 256,
  parameter int unsigned CNT_W    = $clog2(BOOT_MAX) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             boot_i,
  input  logic             bios_valid_i,
  input  logic             bios_done_i,
  output logic             wr_o,
  output logic [CNT_W-1:0] addr_o,
  output logic             exit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;
  logic             last_wr;

  assign full    = (cnt_q >= CNT_W'(BOOT_MAX));
  assign wr_o    = boot_i && bios_valid_i && !full;
  assign last_wr = wr_o && (cnt_q == CNT_W'(BOOT_MAX - 1));
  assign exit_o  = boot_i && (bios_done_i || last_wr || full);
  assign addr_o  = cnt_q;

  // Saturating: the counter never wraps back onto already-loaded words.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_o) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter: BIOS load in BOOT, then fixed-priority
// MEM-over-fetch arbitration with a starvation override and registered read return.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BOOT_MAX = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bios_valid,
  input  logic [DATA_W-1:0] bios_data,
  input  logic              bios_done,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              boot_active,
  output logic              pc_enable
);

  localparam int unsigned CNT_W = $clog2(BOOT_MAX) + 1;

  state_e              state_q, state_d;
  req_id_e             gnt_id;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                boot_en, boot_wr, boot_exit;
  logic [CNT_W-1:0]    boot_addr;
  logic                if_rvalid_q, dm_rvalid_q;
  logic [DATA_W-1:0]   if_rdata_q, dm_rdata_q;

  // Qualified with reset_n so the memory stays idle while reset is held.
  assign boot_en = (state_q == ST_BOOT) && reset_n;

  boot_loader_seq #(.BOOT_MAX(BOOT_MAX), .CNT_W(CNT_W)) u_boot (
    .clock        (clock),
    .reset_n      (reset_n),
    .boot_i       (boot_en),
    .bios_valid_i (bios_valid),
    .bios_done_i  (bios_done),
    .wr_o         (boot_wr),
    .addr_o       (boot_addr),
    .exit_o       (boot_exit)
  );

  always_comb begin
    state_d  = state_q;
    gnt_id   = REQ_NONE;
    starve_d = starve_q;
    if (state_q == ST_BOOT) begin
      if (boot_exit) state_d = ST_RUN;
    end else begin
      if (if_req && (!dm_req || starve_q >= STARVE_W'(STARVE_LIM))) gnt_id = REQ_IF;
      else if (dm_req)                                             gnt_id = REQ_DM;
      // Counts only consecutive denied fetches; any grant or idle fetch clears it.
      if (!if_req || gnt_id == REQ_IF)             starve_d = '0;
      else if (starve_q < STARVE_W'(STARVE_LIM))   starve_d = starve_q + STARVE_W'(1);
    end
  end

  assign if_gnt      = (gnt_id == REQ_IF);
  assign dm_gnt      = (gnt_id == REQ_DM);
  assign pc_enable   = if_gnt;
  assign boot_active = (state_q == ST_BOOT);

  always_comb begin
    mem_cs    = 1'b1;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (boot_wr) begin
      mem_cs    = 1'b0;
      mem_we    = 1'b1;
      mem_addr  = ADDR_W'(boot_addr);
      mem_wdata = bios_data;
    end else if (gnt_id == REQ_IF) begin
      mem_cs   = 1'b0;
      mem_oe   = 1'b1;
      mem_addr = if_addr;
    end else if (gnt_id == REQ_DM) begin
      mem_cs    = 1'b0;
      mem_we    = dm_we;
      mem_oe    = !dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_BOOT;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      if_rvalid_q <= if_gnt;
      dm_rvalid_q <= dm_gnt && !dm_we;
      if (if_gnt)            if_rdata_q <= mem_rdata;
      if (dm_gnt && !dm_we)  dm_rdata_q <= mem_rdata;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;

endmodule
